rc_pulse_decoder: RTL and testbench
===================================

RC_PULSE_DECODER -- requirements
Module: rc_pulse_decoder

Interface
REQ-001 SHALL have one clock and a synchronous active-low reset; all state changes on rising clk edge.
REQ-002 SHALL expose ports: clk  in  1  system clock, 12 MHz.
REQ-003 SHALL expose ports: rst_n  in  1  synchronous active-low reset.
REQ-004 SHALL expose ports: rc_in  in  1  asynchronous RC receiver pulse, high-time encodes command.
REQ-005 SHALL expose ports: controls_out  out  16  unsigned command, 0 = minimum, 65535 = full scale; feeds PWM stage controls_input.
REQ-006 SHALL expose ports: ctrl_valid  out  1  one-cycle strobe, controls_out updated this cycle.
REQ-007 SHALL expose ports: signal_lost  out  1  level, no accepted pulse within timeout.
REQ-008 SHALL expose ports: pulse_err  out  1  one-cycle strobe, pulse rejected.
REQ-009 SHALL use constants: MIN_CYC 12000 (1.0 ms); MAX_CYC 24000 (2.0 ms); REJ_LO_CYC 6000 (0.5 ms); REJ_HI_CYC 30000 (2.5 ms); TIMEOUT_CYC 300000 (25 ms); SCALE_MULT 22369; SCALE_SHIFT 12.

Function
REQ-010 SHALL pass rc_in through a 2-FF synchronizer giving rc_s; rc_d = rc_s delayed one cycle; rise = rc_s & ~rc_d.
REQ-011 SHALL implement FSM states IDLE, MEAS, WAIT_LOW, CALC, OUT.
REQ-012 IDLE: on rise -> MEAS, width_cnt = 1; else stay.
REQ-013 MEAS: while rc_s=1, width_cnt increments by 1 per cycle; width_cnt = cycles rc_s sampled high.
REQ-014 MEAS: if width_cnt reaches REJ_HI_CYC with rc_s still 1 -> pulse_err strobe, WAIT_LOW.
REQ-015 WAIT_LOW: stay until rc_s=0, then IDLE; no output update.
REQ-016 MEAS: on rc_s=0 with width_cnt < REJ_LO_CYC -> pulse_err strobe, IDLE; otherwise -> CALC with width latched.
REQ-017 CALC: clamp = min(max(width, MIN_CYC), MAX_CYC) - MIN_CYC (15-bit, 0..12000); prod = clamp * SCALE_MULT registered (30-bit, unsigned).
REQ-018 OUT: controls_out = 65535 if clamp = 12000, else prod[27:12]; ctrl_valid strobe; -> IDLE.
REQ-019 Latency: ctrl_valid high exactly 4 clk cycles after the first clk edge that samples rc_in low ending an accepted pulse.
REQ-020 Width counter 15 bits, never wraps (REJ_HI_CYC bounds it).
REQ-021 Timeout counter 19 bits: cleared on every pulse-driven ctrl_valid, else increments, saturates at TIMEOUT_CYC.
REQ-022 On timeout counter reaching TIMEOUT_CYC with signal_lost=0: signal_lost = 1, controls_out = 0, ctrl_valid strobe, once per loss event.
REQ-023 signal_lost clears on the next pulse-driven ctrl_valid.
REQ-024 Simultaneous pulse-driven OUT and timeout expiry: pulse result wins, counter cleared, signal_lost stays/returns 0.
REQ-025 Rejected pulses do not clear the timeout counter or change controls_out.

Reset
REQ-026 On rst_n=0: state IDLE; sync FFs 0; rc_d 1; width_cnt 0; timeout counter 0; controls_out 0; ctrl_valid 0; pulse_err 0; signal_lost 1.
REQ-027 Reset mid-measurement SHALL abort with no ctrl_valid or pulse_err.
REQ-028 rc_in high at reset release SHALL NOT be measured; rc_s must first be seen low.

Structure
REQ-029 Package rc_decode_pkg SHALL hold all REQ-009 constants and the FSM state enum.
REQ-030 Synchronizer SHALL be a separate sub-module sync_2ff; all other logic in rc_pulse_decoder.

Verification
REQ-031 1.5 ms pulse (18000 cycles) -> ctrl_valid once, controls_out = 32767, signal_lost 1->0.
REQ-032 1.0 ms, 0.8 ms, 2.0 ms, 2.2 ms pulses -> controls_out 0, 0, 65535, 65535 respectively.
REQ-033 0.4 ms pulse -> pulse_err once, no ctrl_valid; 3.0 ms pulse -> pulse_err at width 30000, no ctrl_valid, return to IDLE after fall.
REQ-034 Valid 1.5 ms pulse, then 25 ms of rc_in=0 -> signal_lost=1, controls_out=0, single ctrl_valid; next 1.5 ms pulse -> signal_lost=0, 32767.
REQ-035 rst_n asserted at 1.0 ms into a 1.5 ms pulse -> all outputs at reset values, no valid for that pulse; next full pulse decoded normally.
REQ-036 rc_in held high through reset release, falls after 1.5 ms -> no ctrl_valid.

Source files
------------

// File: rtl/rc_decode_pkg.sv
// Shared timing constants, datapath widths and FSM encoding for the RC pulse decoder.
// Cycle counts assume a 12 MHz clock.
package rc_decode_pkg;

  localparam int unsigned MIN_CYC     = 12000;   // 1.0 ms
  localparam int unsigned MAX_CYC     = 24000;   // 2.0 ms
  localparam int unsigned REJ_LO_CYC  = 6000;    // 0.5 ms
  localparam int unsigned REJ_HI_CYC  = 30000;   // 2.5 ms
  localparam int unsigned TIMEOUT_CYC = 300000;  // 25 ms
  localparam int unsigned SCALE_MULT  = 22369;
  localparam int unsigned SCALE_SHIFT = 12;

  localparam int WIDTH_W = 15;
  localparam int TO_W    = 19;
  localparam int PROD_W  = 30;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEAS,
    ST_WAIT_LOW,
    ST_CALC,
    ST_OUT
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous receiver pulse into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rc_pulse_decoder.sv
// Measures RC receiver pulse high-time and maps 1.0..2.0 ms onto a 16-bit command,
// with out-of-range rejection and a loss-of-signal timeout.
module rc_pulse_decoder
  import rc_decode_pkg::*;
#(
  parameter int unsigned MIN_LIM     = MIN_CYC,
  parameter int unsigned MAX_LIM     = MAX_CYC,
  parameter int unsigned REJ_LO_LIM  = REJ_LO_CYC,
  parameter int unsigned REJ_HI_LIM  = REJ_HI_CYC,
  parameter int unsigned TIMEOUT_LIM = TIMEOUT_CYC,
  parameter int unsigned MULT        = SCALE_MULT,
  parameter int unsigned SHIFT       = SCALE_SHIFT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rc_in,
  output logic [15:0] controls_out,
  output logic        ctrl_valid,
  output logic        signal_lost,
  output logic        pulse_err
);

  state_t              state;
  logic                rc_s, rc_d, rise, armed;
  logic [1:0]          warm;
  logic [WIDTH_W-1:0]  width_cnt, clamp;
  logic [TO_W-1:0]     to_cnt;
  logic [PROD_W-1:0]   prod_full, prod_p1;
  logic                full_p1;

  function automatic logic [WIDTH_W-1:0] clamp_width(input logic [WIDTH_W-1:0] w);
    logic [WIDTH_W-1:0] lo, hi, sat;
    lo = WIDTH_W'(MIN_LIM);
    hi = WIDTH_W'(MAX_LIM);
    if (w < lo)      sat = lo;
    else if (w > hi) sat = hi;
    else             sat = w;
    return sat - lo;
  endfunction

  // Full-scale width bypasses the product, whose truncation tops out one code short.
  function automatic logic [15:0] scale_cmd(input logic [PROD_W-1:0] prod, input logic full);
    return full ? 16'hFFFF : 16'(prod >> SHIFT);
  endfunction

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rc_in),
    .q     (rc_s)
  );

  // The synchronizer's reset zeros are not a real low level; arm edge detection
  // only once a genuinely sampled low has passed through both flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rc_d  <= 1'b1;
      warm  <= 2'b00;
      armed <= 1'b0;
    end else begin
      rc_d <= rc_s;
      warm <= {warm[0], 1'b1};
      if (warm[1] && !rc_s) armed <= 1'b1;
    end
  end

  assign rise      = rc_s & ~rc_d & armed;
  assign clamp     = clamp_width(width_cnt);
  assign prod_full = PROD_W'({{(32-WIDTH_W){1'b0}}, clamp} * MULT);

  // CALC -> OUT stage boundary
  always_ff @(posedge clk) begin
    if (state == ST_CALC) begin
      prod_p1 <= prod_full;
      full_p1 <= (clamp == WIDTH_W'(MAX_LIM - MIN_LIM));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      width_cnt    <= '0;
      to_cnt       <= '0;
      controls_out <= '0;
      ctrl_valid   <= 1'b0;
      pulse_err    <= 1'b0;
      signal_lost  <= 1'b1;
    end else begin
      ctrl_valid <= 1'b0;
      pulse_err  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (rise) begin
            width_cnt <= WIDTH_W'(1);
            state     <= ST_MEAS;
          end
        end
        ST_MEAS: begin
          if (rc_s) begin
            width_cnt <= width_cnt + 1'b1;
            if (width_cnt == WIDTH_W'(REJ_HI_LIM - 1)) begin
              pulse_err <= 1'b1;
              state     <= ST_WAIT_LOW;
            end
          end else if (width_cnt < WIDTH_W'(REJ_LO_LIM)) begin
            pulse_err <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            state <= ST_CALC;
          end
        end
        ST_WAIT_LOW: if (!rc_s) state <= ST_IDLE;
        ST_CALC:     state <= ST_OUT;
        ST_OUT:      state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase

      // A decoded pulse always takes priority over a coincident timeout expiry.
      if (state == ST_OUT) begin
        controls_out <= scale_cmd(prod_p1, full_p1);
        ctrl_valid   <= 1'b1;
        signal_lost  <= 1'b0;
        to_cnt       <= '0;
      end else if (to_cnt != TO_W'(TIMEOUT_LIM)) begin
        to_cnt <= to_cnt + 1'b1;
      end else if (!signal_lost) begin
        signal_lost  <= 1'b1;
        controls_out <= '0;
        ctrl_valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rc_pulse_decoder.sv
// Bench for rc_pulse_decoder with all cycle limits scaled down by 10 (timeout shortened
// separately); the scaled mapping yields the same command codes as the full-size constants.
module tb_rc_pulse_decoder;

  localparam int TIMEOUT = 8000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rc_in;
  logic [15:0] controls_out;
  logic        ctrl_valid;
  logic        signal_lost;
  logic        pulse_err;

  rc_pulse_decoder #(
    .MIN_LIM     (1200),
    .MAX_LIM     (2400),
    .REJ_LO_LIM  (600),
    .REJ_HI_LIM  (3000),
    .TIMEOUT_LIM (TIMEOUT),
    .MULT        (223690),
    .SHIFT       (12)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rc_in        (rc_in),
    .controls_out (controls_out),
    .ctrl_valid   (ctrl_valid),
    .signal_lost  (signal_lost),
    .pulse_err    (pulse_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cmd;
    logic        lost;
  } exp_t;

  typedef struct {
    int          width;
    logic        acc;
    logic [15:0] cmd;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl[14];
  int          checks = 0;
  int          errors = 0;
  int          valid_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] last_cmd = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (pulse_err) err_cnt++;
    if (ctrl_valid) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got controls_out=%0d signal_lost=%0b, required no strobe",
                 controls_out, signal_lost);
      end else begin
        e = sb.pop_front();
        chk("valid_cmd", 32'(controls_out), 32'(e.cmd));
        chk("valid_lost", 32'(signal_lost), 32'(e.lost));
      end
    end
  end

  task automatic expect_out(input logic [15:0] cmd, input logic lost);
    exp_t e;
    e.cmd  = cmd;
    e.lost = lost;
    sb.push_back(e);
  endtask

  task automatic pulse(input int w);
    @(negedge clk);
    rc_in = 1'b1;
    repeat (w) @(negedge clk);
    rc_in = 1'b0;
  endtask

  task automatic run_vec(input string name, input int w, input logic acc, input logic [15:0] cmd);
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    if (acc) expect_out(cmd, 1'b0);
    pulse(w);
    repeat (20) @(negedge clk);
    chk({name, "_valid"}, 32'(valid_cnt - v0), acc ? 32'd1 : 32'd0);
    chk({name, "_err"}, 32'(err_cnt - e0), acc ? 32'd0 : 32'd1);
    chk({name, "_drain"}, 32'(sb.size()), 32'd0);
    if (acc) last_cmd = cmd;
    chk({name, "_hold"}, 32'(controls_out), 32'(last_cmd));
    repeat (10) @(negedge clk);
  endtask

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog: simulation did not finish within cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int v0, e0, lat;

    tbl[0]  = '{1800, 1'b1, 16'd32767};
    tbl[1]  = '{1200, 1'b1, 16'd0};
    tbl[2]  = '{960,  1'b1, 16'd0};
    tbl[3]  = '{2400, 1'b1, 16'd65535};
    tbl[4]  = '{2640, 1'b1, 16'd65535};
    tbl[5]  = '{480,  1'b0, 16'd0};
    tbl[6]  = '{1500, 1'b1, 16'd16383};
    tbl[7]  = '{3600, 1'b0, 16'd0};
    tbl[8]  = '{2399, 1'b1, 16'd65479};
    tbl[9]  = '{600,  1'b1, 16'd0};
    tbl[10] = '{599,  1'b0, 16'd0};
    tbl[11] = '{1201, 1'b1, 16'd54};
    tbl[12] = '{3000, 1'b0, 16'd0};
    tbl[13] = '{2999, 1'b1, 16'd65535};

    rc_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd", 32'(controls_out), 32'd0);
    chk("rst_valid", 32'(ctrl_valid), 32'd0);
    chk("rst_err", 32'(pulse_err), 32'd0);
    chk("rst_lost", 32'(signal_lost), 32'd1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("lost_after_reset", 32'(signal_lost), 32'd1);

    for (int i = 0; i < 14; i++)
      run_vec($sformatf("vec%0d", i), tbl[i].width, tbl[i].acc, tbl[i].cmd);

    // Latency from the first edge sampling rc_in low to the strobe.
    expect_out(16'd32767, 1'b0);
    pulse(1800);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (ctrl_valid) lat = i;
    end
    chk("latency_negedges", 32'(lat), 32'd5);
    repeat (20) @(negedge clk);
    chk("latency_drain", 32'(sb.size()), 32'd0);
    last_cmd = 16'd32767;

    // Loss of signal after a quiet period, then recovery.
    v0 = valid_cnt;
    expect_out(16'd0, 1'b1);
    for (int i = 0; i < TIMEOUT + 500 && sb.size() != 0; i++) @(negedge clk);
    chk("timeout_fired", 32'(sb.size()), 32'd0);
    chk("timeout_lost", 32'(signal_lost), 32'd1);
    chk("timeout_cmd", 32'(controls_out), 32'd0);
    repeat (2000) @(negedge clk);
    chk("timeout_once", 32'(valid_cnt - v0), 32'd1);
    last_cmd = 16'd0;
    run_vec("recover", 1800, 1'b1, 16'd32767);

    // Reset 1.0 ms into a 1.5 ms pulse.
    v0 = valid_cnt;
    e0 = err_cnt;
    @(negedge clk);
    rc_in = 1'b1;
    repeat (1200) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_cmd", 32'(controls_out), 32'd0);
    chk("midrst_lost", 32'(signal_lost), 32'd1);
    chk("midrst_valid", 32'(ctrl_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (600) @(negedge clk);
    rc_in = 1'b0;
    repeat (30) @(negedge clk);
    chk("midrst_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("midrst_no_err", 32'(err_cnt - e0), 32'd0);
    last_cmd = 16'd0;
    run_vec("post_reset", 1800, 1'b1, 16'd32767);

    // rc_in held high across reset release.
    v0 = valid_cnt;
    e0 = err_cnt;
    rc_in = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (1800) @(negedge clk);
    rc_in = 1'b0;
    repeat (30) @(negedge clk);
    chk("held_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("held_no_err", 32'(err_cnt - e0), 32'd0);
    chk("held_lost", 32'(signal_lost), 32'd1);
    last_cmd = 16'd0;
    run_vec("after_held", 2100, 1'b1, 16'd49150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
